// File: rtl/prg_uart_loader_if.sv
// rtl/prg_uart_loader_if.sv - received byte stream in, program-RAM write port out
interface prg_uart_loader_if #(
  parameter int ADDR_W = 14
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              prg_we;
  logic [ADDR_W-1:0] prg_addr;
  logic [31:0]       prg_wdata;

  // master is the loader: it consumes bytes and drives the RAM write port
  modport master (
    input  rx_data,
    input  rx_valid,
    output prg_we,
    output prg_addr,
    output prg_wdata
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  prg_we,
    input  prg_addr,
    input  prg_wdata
  );
endinterface

// File: rtl/prg_uart_loader.sv
// rtl/prg_uart_loader.sv - assembles a framed UART program image into prgRAM words
module prg_uart_loader #(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 10_000_000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start_pg,
  prg_uart_loader_if.master    bus,
  output logic                 cpu_reset,
  output logic                 load_busy,
  output logic                 load_ok,
  output logic                 load_err
);

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CHK, DONE, ERR} state_t;

  localparam int              TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   T_ONE  = TW'(1);
  localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);
  localparam logic [16:0]     MAX_N  = 17'(1) << ADDR_W;
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

  state_t            state, state_n;
  logic [15:0]       len;
  logic [16:0]       word_cnt;
  logic [1:0]        byte_cnt;
  logic [7:0]        csum;
  logic [31:0]       word;
  logic [TW-1:0]     timer;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic        busy;
  logic        take;
  logic [16:0] n_full;
  logic        last_word;

  assign busy      = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CHK);
  assign take      = busy && bus.rx_valid && !start_pg;
  assign n_full    = {1'b0, bus.rx_data, len[7:0]};
  assign last_word = (word_cnt + 17'd1) == {1'b0, len};

  assign bus.prg_we    = we_q;
  assign bus.prg_addr  = addr_q;
  assign bus.prg_wdata = wdata_q;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE, ERR: if (start_pg) state_n = LEN0;
      LEN0: if (bus.rx_valid) state_n = LEN1;
      LEN1: if (bus.rx_valid) state_n = (n_full == 17'd0 || n_full > MAX_N) ? ERR : DATA;
      DATA: if (bus.rx_valid && byte_cnt == 2'd3 && last_word) state_n = CHK;
      CHK:  if (bus.rx_valid) state_n = (bus.rx_data == csum) ? DONE : ERR;
      default: state_n = IDLE;
    endcase
    // a byte arriving on the expiry cycle still counts, so only a silent cycle times out
    if (busy && !bus.rx_valid && timer == T_LAST) state_n = ERR;
    if (busy && start_pg) state_n = LEN0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      len       <= '0;
      word_cnt  <= '0;
      byte_cnt  <= '0;
      csum      <= '0;
      word      <= '0;
      timer     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_reset <= 1'b0;
      load_busy <= 1'b0;
      load_ok   <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (we_q) addr_q <= addr_q + A_ONE;

      if (start_pg) begin
        addr_q   <= '0;
        word_cnt <= '0;
        byte_cnt <= '0;
        csum     <= '0;
        timer    <= '0;
        load_ok  <= 1'b0;
        load_err <= 1'b0;
      end else if (take) begin
        timer <= '0;
        case (state)
          LEN0: len[7:0]  <= bus.rx_data;
          LEN1: len[15:8] <= bus.rx_data;
          DATA: begin
            word[8*byte_cnt +: 8] <= bus.rx_data;
            csum     <= csum ^ bus.rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              we_q     <= 1'b1;
              wdata_q  <= {bus.rx_data, word[23:0]};
              word_cnt <= word_cnt + 17'd1;
            end
          end
          default: ;
        endcase
      end else if (busy) begin
        timer <= timer + T_ONE;
      end

      if (state_n == DONE && state != DONE) load_ok  <= 1'b1;
      if (state_n == ERR  && state != ERR)  load_err <= 1'b1;

      cpu_reset <= (state_n != IDLE) && (state_n != DONE);
      load_busy <= (state_n == LEN0) || (state_n == LEN1) || (state_n == DATA) || (state_n == CHK);
    end
  end

endmodule

// File: tb/tb_prg_uart_loader.sv
// tb/tb_prg_uart_loader.sv - directed bench with a write scoreboard for prg_uart_loader
module tb_prg_uart_loader;
  localparam int ADDR_W  = 14;
  localparam int TIMEOUT = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start_pg = 1'b0;
  logic cpu_reset, load_busy, load_ok, load_err;

  prg_uart_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prg_uart_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock     (clock),
    .reset     (reset),
    .start_pg  (start_pg),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .load_busy (load_busy),
    .load_ok   (load_ok),
    .load_err  (load_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    wr_t e;
    if (bus.prg_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_we", {31'd0, bus.prg_we}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(bus.prg_addr), 32'(e.addr));
        chk("wr_data", bus.prg_wdata, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic pulse_start();
    start_pg = 1'b1;
    step();
    start_pg = 1'b0;
  endtask

  // checksum is the XOR of every data byte, computed here from the words sent
  task automatic send_frame(input logic [31:0] words[$], input bit good, input int gap);
    logic [7:0]  cs;
    logic [15:0] n;
    logic [7:0]  b;
    cs = 8'h00;
    n  = 16'(words.size());
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
    for (int i = 0; i < words.size(); i++) begin
      sb.push_back('{addr: ADDR_W'(i), data: words[i]});
      for (int k = 0; k < 4; k++) begin
        b  = words[i][8*k +: 8];
        cs = cs ^ b;
        send_byte(b, gap);
      end
    end
    chk("cpu_reset_before_chk", {31'd0, cpu_reset}, 32'd1);
    send_byte(good ? cs : 8'h00, gap);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] two_words[$];
    logic [31:0] one_word[$];
    two_words = '{32'h1234_5678, 32'hDEAD_BEEF};
    one_word  = '{32'h4433_2211};
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    repeat (3) step();
    chk("rst_prg_we",    {31'd0, bus.prg_we}, 32'd0);
    chk("rst_prg_addr",  32'(bus.prg_addr), 32'd0);
    chk("rst_prg_wdata", bus.prg_wdata, 32'd0);
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    chk("rst_load_busy", {31'd0, load_busy}, 32'd0);
    chk("rst_load_ok",   {31'd0, load_ok}, 32'd0);
    chk("rst_load_err",  {31'd0, load_err}, 32'd0);
    reset = 1'b0;
    step();

    send_byte(8'hA5, 0);
    send_byte(8'h5A, 2);
    chk("idle_busy",      {31'd0, load_busy}, 32'd0);
    chk("idle_cpu_reset", {31'd0, cpu_reset}, 32'd0);

    pulse_start();
    chk("start_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("start_busy",      {31'd0, load_busy}, 32'd1);
    send_frame(two_words, 1'b1, 0);
    chk("b2b_load_ok",   {31'd0, load_ok}, 32'd1);
    chk("b2b_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    chk("b2b_busy",      {31'd0, load_busy}, 32'd0);
    chk("b2b_sb_empty",  32'(sb.size()), 32'd0);

    pulse_start();
    chk("restart_clears_ok", {31'd0, load_ok}, 32'd0);
    send_frame(two_words, 1'b1, 5);
    chk("gap_load_ok",   {31'd0, load_ok}, 32'd1);
    chk("gap_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    chk("gap_sb_empty",  32'(sb.size()), 32'd0);

    pulse_start();
    send_frame(two_words, 1'b0, 0);
    chk("badchk_err",       {31'd0, load_err}, 32'd1);
    chk("badchk_ok",        {31'd0, load_ok}, 32'd0);
    chk("badchk_sb_empty",  32'(sb.size()), 32'd0);
    repeat (10) step();
    chk("badchk_cpu_reset_held", {31'd0, cpu_reset}, 32'd1);

    pulse_start();
    chk("restart_clears_err", {31'd0, load_err}, 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("n0_err",  {31'd0, load_err}, 32'd1);
    chk("n0_busy", {31'd0, load_busy}, 32'd0);

    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h40, 0);
    chk("nbig_err", {31'd0, load_err}, 32'd1);
    repeat (4) step();

    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    repeat (TIMEOUT - 1) step();
    chk("to_not_yet_busy", {31'd0, load_busy}, 32'd1);
    chk("to_not_yet_err",  {31'd0, load_err}, 32'd0);
    step();
    chk("to_err",       {31'd0, load_err}, 32'd1);
    chk("to_busy",      {31'd0, load_busy}, 32'd0);
    chk("to_cpu_reset", {31'd0, cpu_reset}, 32'd1);

    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    start_pg     = 1'b1;
    bus.rx_data  = 8'hCC;
    bus.rx_valid = 1'b1;
    step();
    start_pg     = 1'b0;
    bus.rx_valid = 1'b0;
    chk("collide_busy", {31'd0, load_busy}, 32'd1);
    chk("collide_err",  {31'd0, load_err}, 32'd0);
    send_frame(one_word, 1'b1, 0);
    chk("collide_ok",       {31'd0, load_ok}, 32'd1);
    chk("collide_sb_empty", 32'(sb.size()), 32'd0);

    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    chk("midrst_busy",      {31'd0, load_busy}, 32'd0);
    chk("midrst_we",        {31'd0, bus.prg_we}, 32'd0);
    send_byte(8'hDD, 3);
    chk("midrst_sb_empty",  32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
